restoring_div: RTL and testbench
================================

// Module: restoring_div
// PURPOSE
//  Sequential signed radix-2 restoring divider; the inverse companion of the Booth radix-4 multiplier in the arithmetic library.
//  Computes quotient/remainder of two's-complement operands, one quotient bit per clock, under the same vld_in/done handshake.
//  Truncating (C-style) semantics: quotient rounds toward zero, remainder takes the sign of the dividend.
// PARAMETERS
//  WIDTH_N  8  dividend and quotient width (bits, signed)
//  WIDTH_D  8  divisor and remainder width (bits, signed); WIDTH_D <= WIDTH_N
// PORTS
//  clk           in   1        single clock, rising edge
//  rst           in   1        reset, asynchronous, active-high
//  vld_in        in   1        request; must stay high for the whole operation
//  dividend      in   WIDTH_N  signed dividend, sampled in IDLE
//  divisor       in   WIDTH_D  signed divisor, sampled in IDLE
//  quotient      out  WIDTH_N  signed quotient, registered
//  remainder     out  WIDTH_D  signed remainder, registered
//  div_by_zero   out  1        high with done when divisor == 0
//  done          out  1        one-cycle result-valid pulse
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE; quotient, remainder, div_by_zero, done, count and all datapath regs = 0.
//  - States: IDLE -> CALC -> FIX -> DONE -> IDLE. Any clock edge with vld_in=0 forces IDLE (abort); done stays 0,
//    quotient/remainder/div_by_zero keep their previous values.
//  - IDLE, vld_in=1: latch |dividend| (WIDTH_N-bit unsigned), |divisor| (WIDTH_D-bit unsigned), sign_q = sN^sD,
//    sign_r = sN, partial remainder P (WIDTH_D+1 bits) = 0, count = 0. divisor==0 -> set dbz, go FIX; else go CALC.
//  - CALC, one step per edge: {P,Q} <<= 1; T = P - |D|; if T >= 0 then P=T, Q[0]=1 else Q[0]=0 (restore).
//    count increments; after WIDTH_N steps (count == WIDTH_N-1 at the edge) go FIX.
//  - FIX: quotient = sign_q ? -Q : Q; remainder = sign_r ? -P[WIDTH_D-1:0] : P[WIDTH_D-1:0]; div_by_zero = dbz.
//    dbz case: quotient = all ones, remainder = dividend[WIDTH_D-1:0], div_by_zero = 1. Go DONE.
//  - DONE: done = 1 for exactly this cycle; next edge -> IDLE. If vld_in still high, IDLE starts a new operation
//    on the following edge (back-to-back; operands re-sampled).
//  - Latency: vld_in first sampled at edge k -> done high in the cycle after edge k+WIDTH_N+1 (k+1 for div-by-zero).
//  - Results hold from FIX until the next FIX; never cleared by abort, only by rst.
//  - Overflow: most-negative / -1 wraps: quotient = most-negative, remainder = 0 (falls out of unsigned magnitudes).
//  - Magnitudes use unsigned WIDTH_N / WIDTH_D bits so -2^(W-1) is represented exactly; no extra sign bit needed.
//  - div_by_zero is cleared at the next non-zero FIX; done is purely a function of state (Moore, registered).
//  - rst asserted mid-CALC: immediate IDLE, outputs zeroed; no done pulse.
// STRUCTURE
//  - Shared package arith_pkg: state encoding (IDLE=2'b00, CALC=2'b01, FIX=2'b11, DONE=2'b10), abs/negate helper functions.
//  - One sub-module: div_restore_step (combinational): in P, Q, |D|; out next P, next Q. Instantiated once in CALC path.
//  - Top holds FSM, count (clog2(WIDTH_N) bits), operand/sign registers and output registers.
// TESTING (WIDTH_N=WIDTH_D=8)
//  - 100 / 7, vld_in held -> done 10 cycles after start; quotient=14 (0x0E), remainder=2, div_by_zero=0.
//  - -100 / 7 -> quotient=0xF2 (-14), remainder=0xFE (-2); 100 / -7 -> quotient=0xF2, remainder=0x02.
//  - -128 / -1 -> quotient=0x80, remainder=0x00; -128 / 1 -> quotient=0x80, remainder=0.
//  - 55 / 0 -> done 2 cycles after start, quotient=0xFF, remainder=0x37, div_by_zero=1; next 9/3 clears it (q=3, r=0).
//  - Abort: drop vld_in at CALC step 4 -> IDLE next edge, no done, outputs unchanged; re-raise -> correct result.
//  - Assert rst mid-CALC -> all outputs 0 immediately; back-to-back vld_in high -> done pulses every 11 cycles.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic helpers: divider FSM state encoding and magnitude/negate functions.
// Latency: n/a (package only, no ports).
// Backpressure: n/a. Callers sign- or zero-extend operands into arith_word_t, then size-cast the result back.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b11,
    DONE = 2'b10
  } div_state_e;

  // Widest operand the helpers handle; callers size-cast the result back to their own width.
  localparam int unsigned ARITH_MAXW = 32;
  typedef logic [ARITH_MAXW-1:0] arith_word_t;

  // Two's-complement negate, modulo 2^ARITH_MAXW.
  function automatic arith_word_t negate(input arith_word_t x);
    return (~x) + arith_word_t'(1);
  endfunction

  // Magnitude of a sign-extended value. The most negative W-bit value maps to 2^(W-1),
  // which still fits once truncated to W unsigned bits.
  function automatic arith_word_t abs_val(input arith_word_t x);
    return x[ARITH_MAXW-1] ? negate(x) : x;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift {P,Q} left one bit, trial-subtract |D|, keep or restore.
// Latency: combinational.
// Backpressure: none. Ports: p_i/q_i/d_i current partial remainder, quotient shift reg and divisor magnitude;
// p_o/q_o next values.
module div_restore_step #(
  parameter int unsigned WIDTH_N = 8,
  parameter int unsigned WIDTH_D = 8
) (
  input  logic [WIDTH_D:0]   p_i,
  input  logic [WIDTH_N-1:0] q_i,
  input  logic [WIDTH_D-1:0] d_i,
  output logic [WIDTH_D:0]   p_o,
  output logic [WIDTH_N-1:0] q_o
);

  logic [WIDTH_D+1:0] p_sh;
  logic [WIDTH_D+1:0] diff;
  logic               fits;

  // P stays below |D|, so the shifted value is below 2^(WIDTH_D+1) and the top bit of
  // diff is a clean borrow flag.
  assign p_sh = {p_i, q_i[WIDTH_N-1]};
  assign diff = p_sh - {2'b00, d_i};
  assign fits = ~diff[WIDTH_D+1];

  assign p_o = fits ? diff[WIDTH_D:0] : p_sh[WIDTH_D:0];
  assign q_o = {q_i[WIDTH_N-2:0], fits};

endmodule

// File: rtl/restoring_div.sv
// Signed radix-2 restoring divider (truncating quotient, remainder takes the dividend's sign).
// Latency: done pulses WIDTH_N+2 cycles after the first vld_in edge, or 2 cycles for a zero divisor.
// Backpressure: vld_in must stay high for the whole operation; dropping it aborts to IDLE.
// Ports: clk/rst (async active-high); vld_in, dividend and divisor request;
// quotient, remainder, div_by_zero and done results.
module restoring_div
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH_N = 8,
  parameter int unsigned WIDTH_D = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vld_in,
  input  logic signed [WIDTH_N-1:0] dividend,
  input  logic signed [WIDTH_D-1:0] divisor,
  output logic signed [WIDTH_N-1:0] quotient,
  output logic signed [WIDTH_D-1:0] remainder,
  output logic                      div_by_zero,
  output logic                      done
);

  localparam int unsigned CW = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH_N - 1);

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH_D:0]   p_q, p_d;
  logic [WIDTH_N-1:0] q_q, q_d;
  logic [WIDTH_D-1:0] d_q, d_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH_N-1:0] quotient_q, quotient_d;
  logic [WIDTH_D-1:0] remainder_q, remainder_d;
  logic               div_by_zero_q, div_by_zero_d;

  logic [WIDTH_N-1:0] dvd_mag;
  logic [WIDTH_D-1:0] dvs_mag;
  logic [WIDTH_N-1:0] quo_neg;
  logic [WIDTH_D-1:0] rem_mag;
  logic [WIDTH_D-1:0] rem_neg;
  logic [WIDTH_D:0]   step_p;
  logic [WIDTH_N-1:0] step_q;

  assign dvd_mag = WIDTH_N'(abs_val(arith_word_t'(dividend)));
  assign dvs_mag = WIDTH_D'(abs_val(arith_word_t'(divisor)));
  assign quo_neg = WIDTH_N'(negate(arith_word_t'(q_q)));

  // With a zero divisor Q still holds |dividend|, so re-applying the dividend sign to its low
  // bits reproduces dividend[WIDTH_D-1:0] without keeping the raw operand around.
  assign rem_mag = dbz_q ? q_q[WIDTH_D-1:0] : p_q[WIDTH_D-1:0];
  assign rem_neg = WIDTH_D'(negate(arith_word_t'(rem_mag)));

  div_restore_step #(
    .WIDTH_N (WIDTH_N),
    .WIDTH_D (WIDTH_D)
  ) u_step (
    .p_i (p_q),
    .q_i (q_q),
    .d_i (d_q),
    .p_o (step_p),
    .q_o (step_q)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    p_d           = p_q;
    q_d           = q_q;
    d_d           = d_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    dbz_d         = dbz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    if (!vld_in) begin
      // Abort: back to IDLE, published results untouched.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          q_d       = dvd_mag;
          d_d       = dvs_mag;
          p_d       = '0;
          cnt_d     = '0;
          neg_quo_d = dividend[WIDTH_N-1] ^ divisor[WIDTH_D-1];
          neg_rem_d = dividend[WIDTH_N-1];
          dbz_d     = (divisor == '0);
          state_d   = (divisor == '0) ? FIX : CALC;
        end
        CALC: begin
          p_d   = step_p;
          q_d   = step_q;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) state_d = FIX;
        end
        FIX: begin
          if (dbz_q) begin
            quotient_d = '1;
          end else begin
            quotient_d = neg_quo_q ? quo_neg : q_q;
          end
          remainder_d   = neg_rem_q ? rem_neg : rem_mag;
          div_by_zero_d = dbz_q;
          state_d       = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      p_q           <= '0;
      q_q           <= '0;
      d_q           <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      dbz_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      p_q           <= p_d;
      q_q           <= q_d;
      d_q           <= d_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      dbz_q         <= dbz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_restoring_div.sv
module tb_restoring_div;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld_in = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  restoring_div #(.WIDTH_N(8), .WIDTH_D(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .vld_in      (vld_in),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .done        (done)
  );

  typedef struct {
    logic [7:0] n;
    logic [7:0] d;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // C-style truncating division on plain integers; -128/-1 wraps when truncated to 8 bits.
  task automatic model(input logic [7:0] n, input logic [7:0] d,
                       output logic [7:0] q, output logic [7:0] r, output logic z);
    int ni, di;
    ni = $signed(n);
    di = $signed(d);
    if (di == 0) begin
      q = 8'hFF;
      r = n;
      z = 1'b1;
    end else begin
      q = 8'(ni / di);
      r = 8'(ni % di);
      z = 1'b0;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] q, input logic [7:0] r, input logic z);
    chk({tag, ".quo"}, quotient, q);
    chk({tag, ".rem"}, remainder, r);
    chk({tag, ".dbz"}, div_by_zero, z);
  endtask

  // One isolated operation: raise vld_in, wait for done, check, drop vld_in, confirm one-cycle pulse.
  task automatic single_op(input string tag, input logic [7:0] n, input logic [7:0] d,
                           input logic [7:0] q, input logic [7:0] r, input logic z);
    int cyc;
    @(negedge clk);
    dividend = n;
    divisor  = d;
    vld_in   = 1'b1;
    wait_done(cyc);
    chk({tag, ".latency"}, cyc, (d == 8'h00) ? 2 : 10);
    check_out(tag, q, r, z);
    vld_in = 1'b0;
    @(negedge clk);
    chk({tag, ".done_width"}, done, 1'b0);
  endtask

  initial begin
    vec_t       tbl[7];
    logic [7:0] eq, er, na, da;
    logic       ez;
    int         cyc;
    int         saw_done;

    tbl[0] = '{8'd100,  8'd7,   8'h0E, 8'h02, 1'b0};
    tbl[1] = '{8'h9C,   8'd7,   8'hF2, 8'hFE, 1'b0};  // -100 / 7
    tbl[2] = '{8'd100,  8'hF9,  8'hF2, 8'h02, 1'b0};  // 100 / -7
    tbl[3] = '{8'h80,   8'hFF,  8'h80, 8'h00, 1'b0};  // -128 / -1
    tbl[4] = '{8'h80,   8'h01,  8'h80, 8'h00, 1'b0};  // -128 / 1
    tbl[5] = '{8'd55,   8'h00,  8'hFF, 8'h37, 1'b1};  // divide by zero
    tbl[6] = '{8'd9,    8'd3,   8'h03, 8'h00, 1'b0};  // clears div_by_zero

    // Reset state
    @(negedge clk);
    check_out("reset", 8'h00, 8'h00, 1'b0);
    chk("reset.done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with literal expectations
    foreach (tbl[i]) single_op($sformatf("dir%0d", i), tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].r, tbl[i].z);

    // Abort after four CALC steps: no done, outputs keep the 9/3 result
    @(negedge clk);
    dividend = 8'd20;
    divisor  = 8'd3;
    vld_in   = 1'b1;
    repeat (5) @(negedge clk);
    vld_in = 1'b0;
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) saw_done++;
    end
    chk("abort.no_done", saw_done, 0);
    check_out("abort.hold", 8'h03, 8'h00, 1'b0);
    single_op("after_abort", 8'd20, 8'd3, 8'h06, 8'h02, 1'b0);

    // Reset mid-CALC clears outputs asynchronously
    @(negedge clk);
    dividend = 8'hB3;  // -77
    divisor  = 8'd5;
    vld_in   = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_out("midrst", 8'h00, 8'h00, 1'b0);
    chk("midrst.done", done, 1'b0);
    vld_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    single_op("post_rst", 8'hB3, 8'd5, 8'hF1, 8'hFE, 1'b0);  // -77/5 = -15 r -2

    // Randomised isolated operations against the model
    for (int k = 0; k < 30; k++) begin
      na = (k % 7 == 3) ? 8'h80 : 8'($urandom);
      da = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      model(na, da, eq, er, ez);
      single_op($sformatf("rnd%0d", k), na, da, eq, er, ez);
    end

    // Back-to-back: vld_in held high, operands changed at each done
    @(negedge clk);
    na = 8'($urandom);
    da = 8'($urandom) | 8'h01;
    dividend = na;
    divisor  = da;
    vld_in   = 1'b1;
    wait_done(cyc);
    chk("b2b.first_latency", cyc, 10);
    for (int k = 0; k < 12; k++) begin
      model(na, da, eq, er, ez);
      check_out($sformatf("b2b%0d", k), eq, er, ez);
      na = 8'($urandom);
      da = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      dividend = na;
      divisor  = da;
      wait_done(cyc);
      chk($sformatf("b2b%0d.period", k), cyc, (da == 8'h00) ? 3 : 11);
    end
    model(na, da, eq, er, ez);
    check_out("b2b.last", eq, er, ez);
    vld_in = 1'b0;
    @(negedge clk);
    chk("b2b.done_width", done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
